// File: rtl/rv32i_types.sv
// Shared RV32I core types: pipeline-control FSM states, register constants
// and small helpers used by the hazard logic.
package rv32i_types;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    FREEZE = 1'b1
  } pipe_ctrl_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  // True when a source operand is actually read and names the given register.
  function automatic logic src_matches(input logic       use_src,
                                       input logic [4:0] src,
                                       input logic [4:0] dst);
    return use_src & (src == dst);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use hazard compare: the instruction in ID needs a register that the
// load currently in EX has not produced yet. x0 is never a real dependency.
module load_use_detect
  import rv32i_types::*;
(
  input  logic       ex_is_load,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  output logic       hazard
);

  // Compare the EX load destination against both ID sources.
  always_comb begin
    hazard = 1'b0;
    if (ex_is_load && (ex_rd != REG_X0)) begin
      hazard = src_matches(id_use_rs1, id_rs1, ex_rd) |
               src_matches(id_use_rs2, id_rs2, ex_rd);
    end else begin
      hazard = 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: turns cache handshakes, load-use hazards and EX
// mispredicts into per-stage load/flush enables, and keeps saturating
// counters of stall cycles, inserted bubbles and mispredict flushes.
module pipeline_ctrl
  import rv32i_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_mispredict,
  output logic             load_pc,
  output logic             pc_redirect,
  output logic             load_if_id,
  output logic             flush_if_id,
  output logic             load_id_ex,
  output logic             flush_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  pipe_ctrl_state_t state_r;
  logic             imem_done_r;
  logic             dmem_done_r;
  logic             hazard_s;
  logic             i_wait_s;
  logic             d_wait_s;
  logic             freeze_s;
  logic             stall_inc_s;
  logic             flush_inc_s;
  logic             bubble_inc_s;

  // Counters hold at all-ones instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  load_use_detect u_load_use_detect (
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .hazard     (hazard_s)
  );

  // A cache waits only if its response is neither here now nor already seen.
  always_comb begin
    i_wait_s = imem_read & ~imem_resp & ~imem_done_r;
    d_wait_s = dmem_req & ~dmem_resp & ~dmem_done_r;
    freeze_s = i_wait_s | d_wait_s;
  end

  // Per-stage enables; reset drains nops, then freeze > mispredict > hazard.
  always_comb begin
    load_pc      = 1'b1;
    pc_redirect  = 1'b0;
    load_if_id   = 1'b1;
    flush_if_id  = 1'b0;
    load_id_ex   = 1'b1;
    flush_id_ex  = 1'b0;
    load_ex_mem  = 1'b1;
    load_mem_wb  = 1'b1;
    stall_inc_s  = 1'b0;
    flush_inc_s  = 1'b0;
    bubble_inc_s = 1'b0;
    if (rst) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (freeze_s) begin
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
      stall_inc_s = 1'b1;
    end else if (ex_mispredict) begin
      pc_redirect = 1'b1;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      flush_inc_s = 1'b1;
    end else if (hazard_s) begin
      load_pc      = 1'b0;
      load_if_id   = 1'b0;
      flush_id_ex  = 1'b1;
      bubble_inc_s = 1'b1;
    end else begin
      load_pc = 1'b1;
    end
  end

  // RUN/FREEZE state plus done latches that remember early cache responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= RUN;
      imem_done_r <= 1'b0;
      dmem_done_r <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (freeze_s) begin
            state_r     <= FREEZE;
            imem_done_r <= imem_resp;
            dmem_done_r <= dmem_resp;
          end else begin
            state_r     <= RUN;
            imem_done_r <= 1'b0;
            dmem_done_r <= 1'b0;
          end
        end
        FREEZE: begin
          if (freeze_s) begin
            state_r     <= FREEZE;
            imem_done_r <= imem_done_r | imem_resp;
            dmem_done_r <= dmem_done_r | dmem_resp;
          end else begin
            state_r     <= RUN;
            imem_done_r <= 1'b0;
            dmem_done_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= RUN;
          imem_done_r <= 1'b0;
          dmem_done_r <= 1'b0;
        end
      endcase
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= {CNT_W{1'b0}};
      bubble_cnt <= {CNT_W{1'b0}};
      flush_cnt  <= {CNT_W{1'b0}};
    end else begin
      if (stall_inc_s) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
      if (bubble_inc_s) begin
        bubble_cnt <= sat_inc(bubble_cnt);
      end
      if (flush_inc_s) begin
        flush_cnt <= sat_inc(flush_cnt);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hand-computed enable patterns and
// counter values for cache misses, load-use bubbles, mispredicts and reset.
module tb_pipeline_ctrl;

  logic        clk;
  logic        rst;
  logic        imem_read, imem_resp, dmem_req, dmem_resp;
  logic        ex_is_load, id_use_rs1, id_use_rs2, ex_mispredict;
  logic [4:0]  ex_rd, id_rs1, id_rs2;
  logic        load_pc, pc_redirect, load_if_id, flush_if_id;
  logic        load_id_ex, flush_id_ex, load_ex_mem, load_mem_wb;
  logic [31:0] stall_cnt, bubble_cnt, flush_cnt;

  // Packed view {load_pc, pc_redirect, load_if_id, flush_if_id,
  //              load_id_ex, flush_id_ex, load_ex_mem, load_mem_wb}
  localparam logic [7:0] E_NORM   = 8'hAB;
  localparam logic [7:0] E_FRZ    = 8'h00;
  localparam logic [7:0] E_MISP   = 8'hFF;
  localparam logic [7:0] E_BUBBLE = 8'h0F;
  localparam logic [7:0] E_RST    = 8'hBF;

  int n_total;
  int n_bad;

  pipeline_ctrl #(.CNT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_read     (imem_read),
    .imem_resp     (imem_resp),
    .dmem_req      (dmem_req),
    .dmem_resp     (dmem_resp),
    .ex_is_load    (ex_is_load),
    .ex_rd         (ex_rd),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .ex_mispredict (ex_mispredict),
    .load_pc       (load_pc),
    .pc_redirect   (pc_redirect),
    .load_if_id    (load_if_id),
    .flush_if_id   (flush_if_id),
    .load_id_ex    (load_id_ex),
    .flush_id_ex   (flush_id_ex),
    .load_ex_mem   (load_ex_mem),
    .load_mem_wb   (load_mem_wb),
    .stall_cnt     (stall_cnt),
    .bubble_cnt    (bubble_cnt),
    .flush_cnt     (flush_cnt)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total = n_total + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs are already driven; check enables mid-cycle, then commit the edge.
  task automatic cyc(input string tag, input logic [7:0] exp);
    @(negedge clk);
    check(tag, {24'd0, load_pc, pc_redirect, load_if_id, flush_if_id,
                load_id_ex, flush_id_ex, load_ex_mem, load_mem_wb}, {24'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnts(input string tag, input int s, input int b, input int f);
    check({tag, ".stall"},  stall_cnt,  s);
    check({tag, ".bubble"}, bubble_cnt, b);
    check({tag, ".flush"},  flush_cnt,  f);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1;
    imem_read = 1'b1; imem_resp = 1'b1; dmem_req = 1'b0; dmem_resp = 1'b0;
    ex_is_load = 1'b0; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mispredict = 1'b0;

    // Reset drains nops for three cycles.
    for (int i = 0; i < 3; i++) cyc("reset_outs", E_RST);
    rst = 1'b0;
    check_cnts("reset", 0, 0, 0);

    // 1. Straight-line code, hits every cycle.
    for (int i = 0; i < 3; i++) cyc("straight", E_NORM);
    check_cnts("straight", 0, 0, 0);

    // 2. Five-cycle imem miss, advance on the response cycle.
    imem_resp = 1'b0;
    for (int i = 0; i < 5; i++) cyc("imiss", E_FRZ);
    imem_resp = 1'b1;
    cyc("imiss_resp", E_NORM);
    check_cnts("imiss", 5, 0, 0);

    // 3. dmem pulse at cycle 2 remembered while imem misses until cycle 6.
    imem_resp = 1'b0; dmem_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dmem_resp = (i == 2);
      cyc("dpulse_frz", E_FRZ);
    end
    dmem_resp = 1'b0; imem_resp = 1'b1;
    cyc("dpulse_adv", E_NORM);
    check_cnts("dpulse", 11, 0, 0);
    // Done latch cleared by the advance: a fresh dmem request waits again.
    cyc("dpulse_new", E_FRZ);
    dmem_req = 1'b0;
    cyc("dpulse_end", E_NORM);
    check_cnts("dpulse2", 12, 0, 0);

    // 4. lw x5 in EX, add x6,x5,x1 in ID -> one bubble.
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd1;
    id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    cyc("lu_rs1", E_BUBBLE);
    ex_is_load = 1'b0; ex_rd = 5'd0;
    cyc("lu_after", E_NORM);
    check_cnts("lu_rs1", 12, 1, 0);
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
    cyc("lu_x0", E_NORM);
    ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7;
    cyc("lu_rs2", E_BUBBLE);
    id_use_rs2 = 1'b0;
    cyc("lu_unused", E_NORM);
    check_cnts("lu_rs2", 12, 2, 0);

    // 5. Mispredict overrides a simultaneous load-use hazard.
    id_use_rs2 = 1'b1; ex_mispredict = 1'b1;
    cyc("misp_lu", E_MISP);
    ex_mispredict = 1'b0; ex_is_load = 1'b0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    check_cnts("misp_lu", 12, 2, 1);

    // 6. Mispredict held across a three-cycle imem miss, flushed on resp.
    ex_mispredict = 1'b1; imem_resp = 1'b0;
    for (int i = 0; i < 3; i++) cyc("misp_frz", E_FRZ);
    imem_resp = 1'b1;
    cyc("misp_resp", E_MISP);
    check_cnts("misp_frz", 15, 2, 2);

    // Second run: reset in the middle of a freeze.
    ex_mispredict = 1'b0; imem_resp = 1'b0;
    cyc("rst_frz", E_FRZ);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cyc("rst_mid", E_RST);
    rst = 1'b0;
    check_cnts("rst_mid", 0, 0, 0);
    imem_resp = 1'b1;
    cyc("rst_run", E_NORM);
    check_cnts("rst_run", 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
